seq_restoring_divider: RTL



---
 rtl/div_pkg.sv | 15 +
 rtl/create.sv | 12 +
 rtl/seq_restoring_divider_div_step.sv | 27 ++
 rtl/seq_restoring_divider.sv | 108 ++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  // Every quotient bit takes this value when the divisor is zero.
  localparam logic DIV_ZERO_Q_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/create.sv
// Packs the divider P register: upper half = partial remainder (b), lower half = dividend (a).
module create #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  assign p = {b, a};

endmodule

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division step: shift P left, trial-subtract the divisor, restore on borrow.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic [2*WIDTH-1:0] o_p_next
);

  logic [2*WIDTH-1:0] w_shifted;
  logic [WIDTH:0]     w_trial;

  assign w_shifted = i_p << 1;

  // The extra bit is the borrow: trial[WIDTH]=1 means the shifted remainder is below the divisor.
  assign w_trial = {1'b0, w_shifted[2*WIDTH-1:WIDTH]} - {1'b0, i_divisor};

  always_comb begin
    // NOTE: assigning a default before any branch keeps a purely combinational block latch-free.
    o_p_next = w_shifted;
    if (!w_trial[WIDTH]) begin
      o_p_next[2*WIDTH-1:WIDTH] = w_trial[WIDTH-1:0];
      o_p_next[0]               = 1'b1;
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock, WIDTH steps per division.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [2*WIDTH-1:0] r_p;
  logic [2*WIDTH-1:0] w_p_init;
  logic [2*WIDTH-1:0] w_p_step;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic [CW-1:0]      r_count;
  logic               r_div_by_zero;
  logic               w_accept;
  logic               w_divisor_zero;
  logic               w_last_step;

  create #(.WIDTH(WIDTH)) u_create (
    .a (dividend),
    .b ({WIDTH{1'b0}}),
    .p (w_p_init)
  );

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_p       (r_p),
    .i_divisor (r_divisor),
    .o_p_next  (w_p_step)
  );

  assign w_accept       = start && (r_state == IDLE);
  assign w_divisor_zero = (divisor == '0);
  assign w_last_step    = (r_state == ITER) && (r_count == CW'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_divisor_zero ? DONE : ITER;
      ITER:    if (w_last_step) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p           <= '0;
      r_divisor     <= '0;
      r_count       <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (w_divisor_zero) begin
        r_quotient    <= {WIDTH{DIV_ZERO_Q_FILL}};
        r_remainder   <= dividend;
        r_div_by_zero <= 1'b1;
      end else begin
        r_p           <= w_p_init;
        r_divisor     <= divisor;
        r_count       <= '0;
        r_div_by_zero <= 1'b0;
      end
    end else if (r_state == ITER) begin
      r_p     <= w_p_step;
      r_count <= r_count + 1'b1;
      if (w_last_step) begin
        r_quotient  <= w_p_step[WIDTH-1:0];
        r_remainder <= w_p_step[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Handshake outputs come straight from the state register: no input-to-output path.
  assign ready       = (r_state == IDLE);
  assign busy        = (r_state == ITER);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
